// File: rtl/mouse_adapter_if.sv
// Packet and output bundle between the HPS mouse source and the mouse_adapter.
// The adapter takes the slave modport; the host or bench takes the master.
interface mouse_adapter_if;
  logic [24:0] ps2_mouse;
  logic [1:0]  mouse_type;
  logic [7:0]  kemp_x;
  logic [7:0]  kemp_y;
  logic [2:0]  kemp_btn;
  logic [3:0]  amx_quad;
  logic [2:0]  amx_btn;
  logic        pkt_strobe;

  modport slave (
    input  ps2_mouse, mouse_type,
    output kemp_x, kemp_y, kemp_btn, amx_quad, amx_btn, pkt_strobe
  );

  modport master (
    output ps2_mouse, mouse_type,
    input  kemp_x, kemp_y, kemp_btn, amx_quad, amx_btn, pkt_strobe
  );
endinterface

// File: rtl/mouse_adapter.sv
// Turns HPS mouse packets into Kempston absolute position or AMX quadrature,
// selected by mouse_type. Every output is driven straight from a register.
module mouse_adapter #(
  parameter int unsigned STEP_DIV = 1600
) (
  input  logic            clk_sys,
  input  logic            reset,
  mouse_adapter_if.slave  bus
);

  localparam logic [15:0] DIV_LAST = 16'(STEP_DIV - 1);
  localparam logic [1:0]  MT_AMX   = 2'd1;
  localparam logic [1:0]  MT_KEMP  = 2'd2;

  logic              init_q, init_d;
  logic              tog_q, tog_d;
  logic [1:0]        mt_q, mt_d;
  logic              strobe_q, strobe_d;
  logic [7:0]        kx_q, kx_d, ky_q, ky_d;
  logic [2:0]        kbtn_q, kbtn_d, abtn_q, abtn_d;
  logic [1:0]        phx_q, phx_d, phy_q, phy_d;
  logic signed [9:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [15:0]       div_q, div_d;

  logic              accept, type_chg, amx, kemp, tick;
  logic signed [8:0] dx, dy;
  logic [7:0]        status;
  logic              unused_status;

  function automatic logic [1:0] ph_fwd(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ph_rev(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Delta and step are folded into one saturating sum so neither is lost
  // when a packet lands on a tick; step direction comes from the old count.
  function automatic logic signed [9:0] pend_next(
    input logic signed [9:0] pend,
    input logic signed [8:0] delta,
    input logic              add,
    input logic              stp
  );
    logic signed [11:0] s;
    s = {{2{pend[9]}}, pend};
    if (add) s = s + {{3{delta[8]}}, delta};
    if (stp && !pend[9] && (pend != 10'sd0)) s = s - 12'sd1;
    else if (stp && pend[9])                 s = s + 12'sd1;
    if (s > 12'sd511)       return 10'sd511;
    else if (s < -12'sd512) return -10'sd512;
    else                    return s[9:0];
  endfunction

  always_comb begin
    status        = bus.ps2_mouse[7:0];
    dx            = {status[4], bus.ps2_mouse[15:8]};
    dy            = {status[5], bus.ps2_mouse[23:16]};
    unused_status = ^{status[7:6], status[3]};
    accept        = !init_q && (bus.ps2_mouse[24] != tog_q);
    type_chg      = bus.mouse_type != mt_q;
    amx           = !type_chg && (bus.mouse_type == MT_AMX);
    kemp          = !type_chg && (bus.mouse_type == MT_KEMP);
    tick          = amx && (div_q == DIV_LAST);

    init_d   = 1'b0;
    tog_d    = bus.ps2_mouse[24];
    mt_d     = bus.mouse_type;
    strobe_d = accept;
    kx_d     = kx_q;
    ky_d     = ky_q;
    kbtn_d   = kbtn_q;
    abtn_d   = abtn_q;
    phx_d    = phx_q;
    phy_d    = phy_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    div_d    = div_q;

    if (type_chg) begin
      pend_x_d = '0;
      pend_y_d = '0;
      div_d    = '0;
      kbtn_d   = '0;
      abtn_d   = '0;
    end else if (amx) begin
      div_d    = tick ? '0 : div_q + 16'd1;
      pend_x_d = pend_next(pend_x_q, dx, accept, tick);
      pend_y_d = pend_next(pend_y_q, dy, accept, tick);
      if (tick && !pend_x_q[9] && (pend_x_q != 10'sd0)) phx_d = ph_fwd(phx_q);
      else if (tick && pend_x_q[9])                     phx_d = ph_rev(phx_q);
      if (tick && !pend_y_q[9] && (pend_y_q != 10'sd0)) phy_d = ph_fwd(phy_q);
      else if (tick && pend_y_q[9])                     phy_d = ph_rev(phy_q);
      if (accept) abtn_d = status[2:0];
    end else if (kemp && accept) begin
      kx_d   = kx_q + dx[7:0];
      ky_d   = ky_q + dy[7:0];
      kbtn_d = status[2:0];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      init_q   <= 1'b1;
      tog_q    <= 1'b0;
      mt_q     <= '0;
      strobe_q <= 1'b0;
      kx_q     <= '0;
      ky_q     <= '0;
      kbtn_q   <= '0;
      abtn_q   <= '0;
      phx_q    <= '0;
      phy_q    <= '0;
      pend_x_q <= '0;
      pend_y_q <= '0;
      div_q    <= '0;
    end else begin
      init_q   <= init_d;
      tog_q    <= tog_d;
      mt_q     <= mt_d;
      strobe_q <= strobe_d;
      kx_q     <= kx_d;
      ky_q     <= ky_d;
      kbtn_q   <= kbtn_d;
      abtn_q   <= abtn_d;
      phx_q    <= phx_d;
      phy_q    <= phy_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      div_q    <= div_d;
    end
  end

  assign bus.kemp_x     = kx_q;
  assign bus.kemp_y     = ky_q;
  assign bus.kemp_btn   = kbtn_q;
  assign bus.amx_quad   = {phx_q, phy_q};
  assign bus.amx_btn    = abtn_q;
  assign bus.pkt_strobe = strobe_q;

endmodule

// File: tb/tb_mouse_adapter.sv
// Directed bench for mouse_adapter with STEP_DIV=4: reset, Kempston wrap,
// mode isolation, AMX stepping, saturation, tick collision and mode switching.
module tb_mouse_adapter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mouse_adapter_if bus();

  mouse_adapter #(.STEP_DIV(4)) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input logic [7:0] y, input logic [7:0] x, input logic [7:0] st);
    bus.ps2_mouse = {~bus.ps2_mouse[24], y, x, st};
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  logic [3:0] vals [8];
  int         at   [8];
  int         nch, nstrobe, nbad;
  logic [3:0] prevq;
  logic [1:0] prevx;
  logic       found;

  initial begin
    rst            = 1'b1;
    bus.ps2_mouse  = {1'b1, 24'h0};
    bus.mouse_type = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_kemp_x", bus.kemp_x, 0);
    chk("rst_kemp_y", bus.kemp_y, 0);
    chk("rst_kemp_btn", bus.kemp_btn, 0);
    chk("rst_amx_quad", bus.amx_quad, 0);
    chk("rst_amx_btn", bus.amx_btn, 0);
    chk("rst_strobe", bus.pkt_strobe, 0);
    chk("rst_pend_x", dut.pend_x_q, 0);
    chk("rst_div", dut.div_q, 0);

    // release with toggle=1 held: no packet
    rst = 1'b0;
    nstrobe = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.pkt_strobe) nstrobe++;
    end
    chk("release_no_strobe", nstrobe, 0);

    // Kempston basic
    pkt(8'h03, 8'h05, 8'h01);
    cyc();
    chk("kemp_strobe", bus.pkt_strobe, 1);
    chk("kemp_x1", bus.kemp_x, 8'h05);
    chk("kemp_y1", bus.kemp_y, 8'h03);
    chk("kemp_btn1", bus.kemp_btn, 3'b001);
    cyc();
    chk("kemp_strobe_1cyc", bus.pkt_strobe, 0);

    // negative deltas, overflow bits ignored
    pkt(8'h00, 8'hFD, 8'hD0);
    cyc();
    chk("kemp_x2", bus.kemp_x, 8'h02);
    chk("kemp_y2", bus.kemp_y, 8'h03);
    chk("kemp_btn2", bus.kemp_btn, 3'b000);
    pkt(8'h00, 8'hFB, 8'h10);
    cyc();
    chk("kemp_x_wrap_neg", bus.kemp_x, 8'hFD);
    pkt(8'hFE, 8'h05, 8'h24);
    cyc();
    chk("kemp_x_wrap_pos", bus.kemp_x, 8'h02);
    chk("kemp_y3", bus.kemp_y, 8'h01);
    chk("kemp_btn3", bus.kemp_btn, 3'b100);

    // mode 3: strobe only, no state change
    bus.mouse_type = 2'd3;
    cyc();
    chk("m3_btn_cleared", bus.kemp_btn, 0);
    chk("m3_x_kept", bus.kemp_x, 8'h02);
    pkt(8'h10, 8'h10, 8'h07);
    cyc();
    chk("m3_strobe", bus.pkt_strobe, 1);
    chk("m3_x_held", bus.kemp_x, 8'h02);
    chk("m3_y_held", bus.kemp_y, 8'h01);
    chk("m3_kbtn_held", bus.kemp_btn, 0);
    chk("m3_abtn_held", bus.amx_btn, 0);

    // AMX dx=+3 dy=-2
    bus.mouse_type = 2'd1;
    cyc();
    pkt(8'hFE, 8'h03, 8'h22);
    cyc();
    chk("amx_strobe", bus.pkt_strobe, 1);
    chk("amx_btn", bus.amx_btn, 3'b010);
    nch = 0;
    for (int i = 0; i < 40; i++) begin
      prevq = bus.amx_quad;
      cyc();
      if (bus.amx_quad != prevq) begin
        if (nch < 8) begin
          vals[nch] = bus.amx_quad;
          at[nch]   = i;
        end
        nch++;
      end
    end
    chk("amx31_nchanges", nch, 3);
    if (nch == 3) begin
      chk("amx31_step1", vals[0], 4'b0110);
      chk("amx31_step2", vals[1], 4'b1111);
      chk("amx31_step3", vals[2], 4'b1011);
      chk("amx31_gap12", at[1] - at[0], 4);
      chk("amx31_gap23", at[2] - at[1], 4);
    end
    chk("amx31_final", bus.amx_quad, 4'b1011);

    // dx=+1 landing on a tick while pend_x=+1
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (dut.div_q == 16'd0) found = 1'b1;
      else cyc();
    end
    chk("align_div0", found, 1);
    pkt(8'h00, 8'h01, 8'h00);
    cyc();
    cyc();
    cyc();
    chk("coll_pre_quad", bus.amx_quad, 4'b1011);
    pkt(8'h00, 8'h01, 8'h00);
    cyc();
    chk("coll_step", bus.amx_quad, 4'b0011);
    chk("coll_pend", dut.pend_x_q, 1);
    cyc();
    cyc();
    cyc();
    chk("coll_wait", bus.amx_quad, 4'b0011);
    cyc();
    chk("coll_step2", bus.amx_quad, 4'b0111);
    repeat (12) cyc();
    chk("coll_hold", bus.amx_quad, 4'b0111);
    chk("coll_pend0", dut.pend_x_q, 0);

    // saturation: 8 x +127
    for (int i = 0; i < 8; i++) begin
      pkt(8'h00, 8'h7F, 8'h00);
      cyc();
    end
    chk("sat_pend", dut.pend_x_q, 511);
    nch  = 0;
    nbad = 0;
    for (int i = 0; i < 2100; i++) begin
      prevx = bus.amx_quad[3:2];
      cyc();
      if (bus.amx_quad[3:2] != prevx) begin
        nch++;
        if (bus.amx_quad[3:2] != fwd(prevx)) nbad++;
      end
    end
    chk("sat_steps", nch, 511);
    chk("sat_dir", nbad, 0);
    chk("sat_pend_end", dut.pend_x_q, 0);
    chk("sat_y_held", bus.amx_quad[1:0], 2'b11);

    // mode switch 1->2 with pend_x=7
    pkt(8'h00, 8'h07, 8'h01);
    cyc();
    chk("sw_pend7", dut.pend_x_q, 7);
    bus.mouse_type = 2'd2;
    prevq = bus.amx_quad;
    cyc();
    chk("sw_pend_clr", dut.pend_x_q, 0);
    chk("sw_abtn_clr", bus.amx_btn, 0);
    repeat (20) cyc();
    chk("sw_quad_hold", bus.amx_quad, prevq);
    chk("sw_kx_kept", bus.kemp_x, 8'h02);

    // reset mid-step aborts immediately
    bus.mouse_type = 2'd1;
    cyc();
    pkt(8'h00, 8'h14, 8'h00);
    repeat (6) cyc();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_quad", bus.amx_quad, 0);
    chk("mid_rst_pend", dut.pend_x_q, 0);
    chk("mid_rst_kx", bus.kemp_x, 0);
    cyc();
    rst = 1'b0;
    nstrobe = 0;
    nch = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bus.pkt_strobe) nstrobe++;
      if (bus.amx_quad != 4'b0000) nch++;
    end
    chk("mid_rst_no_strobe", nstrobe, 0);
    chk("mid_rst_no_step", nch, 0);
    pkt(8'h00, 8'h00, 8'h00);
    cyc();
    chk("post_rst_strobe", bus.pkt_strobe, 1);
    cyc();
    chk("post_rst_strobe_1cyc", bus.pkt_strobe, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
